// File: rtl/risc_pkg.sv
// Shared definitions for the RR/EX pipeline slice: datapath widths, the PC alias
// register, ALU-op encodings and the per-edge action of the RR->EX register.
package risc_pkg;

    localparam int         RISC_DATA_W  = 16;
    localparam int         RISC_REG_AW  = 3;
    localparam logic [2:0] RISC_PC_REG  = 3'b111;
    localparam int         BUBBLE_CNT_W = 16;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    // What the RR->EX register does on the coming edge, highest priority first.
    typedef enum logic [1:0] {
        ACT_FLUSH     = 2'b00,
        ACT_HOLD      = 2'b01,
        ACT_INTERLOCK = 2'b10,
        ACT_CAPTURE   = 2'b11
    } stage_act_e;

    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc16(input logic [BUBBLE_CNT_W-1:0] value);
        logic [BUBBLE_CNT_W-1:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: EX holds a load whose destination is
// read by the instruction in RR. The PC alias register never interlocks.
module load_use_detect
    import risc_pkg::*;
#(
    parameter int                REG_AW = RISC_REG_AW,
    parameter logic [REG_AW-1:0] PC_REG = REG_AW'(RISC_PC_REG)
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic              ex_reg_wr,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    logic ex_is_load_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // Hazard decode from the EX producer and the RR consumer source indices.
    always_comb begin
        ex_is_load_s = 1'b0;
        rs1_hit_s    = 1'b0;
        rs2_hit_s    = 1'b0;
        load_use     = 1'b0;
        if (ex_valid && ex_mem_rd && ex_reg_wr && (ex_rd != PC_REG)) begin
            ex_is_load_s = 1'b1;
        end else begin
            ex_is_load_s = 1'b0;
        end
        rs1_hit_s = (id_rs1 == ex_rd) && (id_rs1 != PC_REG);
        rs2_hit_s = (id_rs2 == ex_rd) && (id_rs2 != PC_REG);
        if (id_valid && ex_is_load_s) begin
            load_use = rs1_hit_s | rs2_hit_s;
        end else begin
            load_use = 1'b0;
        end
    end

endmodule

// File: rtl/rr_ex_stage.sv
// RR->EX pipeline register with load-use interlock, flush and downstream stall
// handling, plus a saturating count of interlock bubbles.
module rr_ex_stage
    import risc_pkg::*;
#(
    parameter int                DATA_W = RISC_DATA_W,
    parameter int                REG_AW = RISC_REG_AW,
    parameter logic [REG_AW-1:0] PC_REG = REG_AW'(RISC_PC_REG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [DATA_W-1:0]       id_pc,
    input  logic [REG_AW-1:0]       id_rs1,
    input  logic [REG_AW-1:0]       id_rs2,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_reg_wr,
    input  logic                    id_mem_rd,
    input  logic                    id_mem_wr,
    input  logic [1:0]              id_alu_op,
    input  logic [DATA_W-1:0]       id_op1,
    input  logic [DATA_W-1:0]       id_op2,
    input  logic                    flush,
    input  logic                    ext_stall,
    output logic                    rr_ex_valid,
    output logic                    rr_ex_reg_wr,
    output logic                    rr_ex_mem_rd,
    output logic                    rr_ex_mem_wr,
    output logic [1:0]              rr_ex_alu_op,
    output logic [REG_AW-1:0]       rr_ex_rs1,
    output logic [REG_AW-1:0]       rr_ex_rs2,
    output logic [REG_AW-1:0]       rr_ex_rd,
    output logic [DATA_W-1:0]       rr_ex_op1,
    output logic [DATA_W-1:0]       rr_ex_op2,
    output logic [DATA_W-1:0]       rr_ex_pc,
    output logic                    stall_out,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    logic                    valid_r;
    logic                    reg_wr_r;
    logic                    mem_rd_r;
    logic                    mem_wr_r;
    alu_op_e                 alu_op_r;
    logic [REG_AW-1:0]       rs1_r;
    logic [REG_AW-1:0]       rs2_r;
    logic [REG_AW-1:0]       rd_r;
    logic [DATA_W-1:0]       op1_r;
    logic [DATA_W-1:0]       op2_r;
    logic [DATA_W-1:0]       pc_r;
    logic [BUBBLE_CNT_W-1:0] bubble_cnt_r;

    logic                    load_use_s;
    logic                    stall_s;
    stage_act_e              act_s;

    load_use_detect #(
        .REG_AW (REG_AW),
        .PC_REG (PC_REG)
    ) u_load_use_detect (
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .ex_valid  (valid_r),
        .ex_mem_rd (mem_rd_r),
        .ex_reg_wr (reg_wr_r),
        .ex_rd     (rd_r),
        .load_use  (load_use_s)
    );

    // Resolve the edge action; a flush overrides every stall source.
    always_comb begin
        act_s   = ACT_CAPTURE;
        stall_s = 1'b0;
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (ext_stall) begin
            act_s = ACT_HOLD;
        end else if (load_use_s) begin
            act_s = ACT_INTERLOCK;
        end else begin
            act_s = ACT_CAPTURE;
        end
        stall_s = ~flush & (ext_stall | load_use_s);
    end

    // Pipeline register update; bubbles clear every field so EX never sees stale indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r      <= 1'b0;
            reg_wr_r     <= 1'b0;
            mem_rd_r     <= 1'b0;
            mem_wr_r     <= 1'b0;
            alu_op_r     <= ALU_ADD;
            rs1_r        <= {REG_AW{1'b0}};
            rs2_r        <= {REG_AW{1'b0}};
            rd_r         <= {REG_AW{1'b0}};
            op1_r        <= {DATA_W{1'b0}};
            op2_r        <= {DATA_W{1'b0}};
            pc_r         <= {DATA_W{1'b0}};
            bubble_cnt_r <= {BUBBLE_CNT_W{1'b0}};
        end else begin
            case (act_s)
                ACT_CAPTURE: begin
                    valid_r  <= id_valid;
                    reg_wr_r <= id_reg_wr & id_valid;
                    mem_rd_r <= id_mem_rd & id_valid;
                    mem_wr_r <= id_mem_wr & id_valid;
                    alu_op_r <= alu_op_e'(id_alu_op);
                    rs1_r    <= id_rs1;
                    rs2_r    <= id_rs2;
                    rd_r     <= id_rd;
                    op1_r    <= id_op1;
                    op2_r    <= id_op2;
                    pc_r     <= id_pc;
                end
                ACT_HOLD: begin
                    valid_r      <= valid_r;
                    reg_wr_r     <= reg_wr_r;
                    mem_rd_r     <= mem_rd_r;
                    mem_wr_r     <= mem_wr_r;
                    alu_op_r     <= alu_op_r;
                    rs1_r        <= rs1_r;
                    rs2_r        <= rs2_r;
                    rd_r         <= rd_r;
                    op1_r        <= op1_r;
                    op2_r        <= op2_r;
                    pc_r         <= pc_r;
                    bubble_cnt_r <= bubble_cnt_r;
                end
                ACT_INTERLOCK: begin
                    valid_r      <= 1'b0;
                    reg_wr_r     <= 1'b0;
                    mem_rd_r     <= 1'b0;
                    mem_wr_r     <= 1'b0;
                    alu_op_r     <= ALU_ADD;
                    rs1_r        <= {REG_AW{1'b0}};
                    rs2_r        <= {REG_AW{1'b0}};
                    rd_r         <= {REG_AW{1'b0}};
                    op1_r        <= {DATA_W{1'b0}};
                    op2_r        <= {DATA_W{1'b0}};
                    pc_r         <= {DATA_W{1'b0}};
                    bubble_cnt_r <= sat_inc16(bubble_cnt_r);
                end
                default: begin
                    valid_r  <= 1'b0;
                    reg_wr_r <= 1'b0;
                    mem_rd_r <= 1'b0;
                    mem_wr_r <= 1'b0;
                    alu_op_r <= ALU_ADD;
                    rs1_r    <= {REG_AW{1'b0}};
                    rs2_r    <= {REG_AW{1'b0}};
                    rd_r     <= {REG_AW{1'b0}};
                    op1_r    <= {DATA_W{1'b0}};
                    op2_r    <= {DATA_W{1'b0}};
                    pc_r     <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign rr_ex_valid  = valid_r;
    assign rr_ex_reg_wr = reg_wr_r;
    assign rr_ex_mem_rd = mem_rd_r;
    assign rr_ex_mem_wr = mem_wr_r;
    assign rr_ex_alu_op = alu_op_r;
    assign rr_ex_rs1    = rs1_r;
    assign rr_ex_rs2    = rs2_r;
    assign rr_ex_rd     = rd_r;
    assign rr_ex_op1    = op1_r;
    assign rr_ex_op2    = op2_r;
    assign rr_ex_pc     = pc_r;
    assign stall_out    = stall_s;
    assign bubble_cnt   = bubble_cnt_r;

endmodule

// File: tb/tb_rr_ex_stage.sv
// Self-checking bench for rr_ex_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the RR->EX register.
module tb_rr_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [15:0] id_pc;
    logic [2:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_wr, id_mem_rd, id_mem_wr;
    logic [1:0]  id_alu_op;
    logic [15:0] id_op1, id_op2;
    logic        flush, ext_stall;
    logic        rr_ex_valid, rr_ex_reg_wr, rr_ex_mem_rd, rr_ex_mem_wr;
    logic [1:0]  rr_ex_alu_op;
    logic [2:0]  rr_ex_rs1, rr_ex_rs2, rr_ex_rd;
    logic [15:0] rr_ex_op1, rr_ex_op2, rr_ex_pc;
    logic        stall_out;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    // Model of what EX currently holds.
    logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr;
    logic [1:0]  m_alu;
    logic [2:0]  m_rs1, m_rs2, m_rd;
    logic [15:0] m_op1, m_op2, m_pc;
    int          m_cnt;

    localparam logic [2:0] PC_IDX = 3'd7;

    rr_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
        .id_alu_op(id_alu_op), .id_op1(id_op1), .id_op2(id_op2),
        .flush(flush), .ext_stall(ext_stall),
        .rr_ex_valid(rr_ex_valid), .rr_ex_reg_wr(rr_ex_reg_wr),
        .rr_ex_mem_rd(rr_ex_mem_rd), .rr_ex_mem_wr(rr_ex_mem_wr),
        .rr_ex_alu_op(rr_ex_alu_op), .rr_ex_rs1(rr_ex_rs1), .rr_ex_rs2(rr_ex_rs2),
        .rr_ex_rd(rr_ex_rd), .rr_ex_op1(rr_ex_op1), .rr_ex_op2(rr_ex_op2),
        .rr_ex_pc(rr_ex_pc), .stall_out(stall_out), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_bubble();
        m_valid = 1'b0; m_reg_wr = 1'b0; m_mem_rd = 1'b0; m_mem_wr = 1'b0;
        m_alu = 2'd0; m_rs1 = 3'd0; m_rs2 = 3'd0; m_rd = 3'd0;
        m_op1 = 16'd0; m_op2 = 16'd0; m_pc = 16'd0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_cnt = 0;
    endtask

    // EX holds a load into a real register that the RR instruction reads.
    function automatic bit model_hazard();
        if (!id_valid || !m_valid || !m_mem_rd || !m_reg_wr || m_rd == PC_IDX) return 1'b0;
        return (id_rs1 == m_rd) || (id_rs2 == m_rd);
    endfunction

    function automatic bit model_stall();
        if (flush) return 1'b0;
        return ext_stall || model_hazard();
    endfunction

    task automatic model_edge();
        if (flush) begin
            model_bubble();
        end else if (ext_stall) begin
            // frozen
        end else if (model_hazard()) begin
            model_bubble();
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_reg_wr = id_reg_wr && id_valid;
            m_mem_rd = id_mem_rd && id_valid;
            m_mem_wr = id_mem_wr && id_valid;
            m_alu = id_alu_op; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_op1 = id_op1; m_op2 = id_op2; m_pc = id_pc;
        end
    endtask

    task automatic check_all();
        chk("valid", rr_ex_valid, m_valid);
        chk("ctl", {rr_ex_reg_wr, rr_ex_mem_rd, rr_ex_mem_wr, rr_ex_alu_op},
                   {m_reg_wr, m_mem_rd, m_mem_wr, m_alu});
        chk("idx", {rr_ex_rs1, rr_ex_rs2, rr_ex_rd}, {m_rs1, m_rs2, m_rd});
        chk("data", {rr_ex_op1, rr_ex_op2}, {m_op1, m_op2});
        chk("pc", rr_ex_pc, m_pc);
        chk("bubble_cnt", bubble_cnt, m_cnt[15:0]);
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        #1;
        chk("stall", stall_out, model_stall());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic present(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic rw, input logic mr, input logic mw,
                           input logic [15:0] o1, input logic [15:0] o2, input logic [15:0] pc);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_wr = rw; id_mem_rd = mr; id_mem_wr = mw;
        id_op1 = o1; id_op2 = o2; id_pc = pc;
        id_alu_op = 2'($urandom_range(0, 3));
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_stall", stall_out, model_stall());
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ext_stall = 1'b0;
        present(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        chk("reset_stall", stall_out, 1'b0);
        rst = 1'b0;

        // Load-use on rs1: one-cycle bubble, then the consumer with op1 intact.
        present(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0004, 16'h0100);
        step();
        present(1'b1, 3'd3, 3'd4, 3'd5, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0102);
        #1 chk("lu_stall", stall_out, 1'b1);
        step();
        chk("lu_bubble_valid", rr_ex_valid, 1'b0);
        chk("lu_bubble_cnt", bubble_cnt, 16'd1);
        step();
        chk("lu_capture_valid", rr_ex_valid, 1'b1);
        chk("lu_capture_op1", rr_ex_op1, 16'h1234);

        // Load into the PC alias: consumer proceeds without a bubble.
        present(1'b1, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0200);
        step();
        present(1'b1, 3'd1, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h5555, 16'h0202);
        #1 chk("pc_exempt_stall", stall_out, 1'b0);
        step();
        chk("pc_exempt_valid", rr_ex_valid, 1'b1);
        chk("pc_exempt_cnt", bubble_cnt, 16'd1);

        // Flush wins over ext_stall and a live load-use.
        present(1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0300);
        step();
        present(1'b1, 3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0302);
        flush = 1'b1; ext_stall = 1'b1;
        #1 chk("prio_stall", stall_out, 1'b0);
        step();
        chk("prio_valid", rr_ex_valid, 1'b0);
        chk("prio_cnt", bubble_cnt, 16'd1);
        flush = 1'b0; ext_stall = 1'b0;

        // Downstream stall freezes EX for three cycles.
        present(1'b1, 3'd1, 3'd2, 3'd4, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0042, 16'h0400);
        step();
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 3'd5, 3'd6, 3'd1, 1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 16'h0402);
            #1 chk("ext_stall_out", stall_out, 1'b1);
            step();
            chk("ext_frozen_op1", rr_ex_op1, 16'hBEEF);
        end
        ext_stall = 1'b0;
        step();
        chk("ext_resume_pc", rr_ex_pc, 16'h0402);

        // Asynchronous reset mid-cycle with live state, then mid-stall.
        async_reset_pulse();
        present(1'b1, 3'd2, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 16'hC0DE, 16'h0001, 16'h0500);
        step();
        ext_stall = 1'b1;
        present(1'b1, 3'd1, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 16'h7777, 16'h8888, 16'h0502);
        step();
        async_reset_pulse();
        ext_stall = 1'b0;
        step();
        chk("post_rst_capture", rr_ex_op1, 16'h7777);

        // Saturation: preload the counter near the top, then keep interlocking.
        force dut.bubble_cnt_r = 16'hFFFD;
        #1 release dut.bubble_cnt_r;
        m_cnt = 65533;
        chk("cnt_preload", bubble_cnt, 16'hFFFD);
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0600);
            step();
            present(1'b1, 3'd2, 3'd1, 3'd3, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0602);
            step();
            step();
        end
        chk("cnt_saturated", bubble_cnt, 16'hFFFF);

        // Randomized traffic with dense register collisions.
        async_reset_pulse();
        for (int i = 0; i < 3000; i++) begin
            present(1'($urandom_range(0, 3) != 0),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            ext_stall = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
